// File: rtl/eth_mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_mmio_arbiter
// Description : Round-robin arbiter that shares the single sync-read MMIO
//               port of the ethernet controller among num_req_p requesters.
//               Only one transaction is in flight at a time. Each transaction
//               moves through four states: accept (IDLE), a one-cycle
//               strobe (ISSUE), read-data capture (CAPTURE), and a response
//               handshake (RESP).
//
// Optional    : ETH_MMIO_ADDR_CHECK_EN
//               When this macro is defined, misaligned or oversized requests
//               are flagged at accept time. A flagged request is never
//               strobed to the controller. Its response returns data 0 with
//               resp_err_o=1. When the macro is undefined, resp_err_o is
//               tied to 0.
//
// Ports       : clk_i, reset_n_i          clock, async active-low reset
//               req_v_i / req_ready_o     per-requester request handshake
//               req_we_i, req_addr_i,     per-requester packed command
//               req_size_i, req_wdata_i
//               resp_v_o / resp_ready_i   per-requester response handshake
//               resp_data_o, resp_err_o   shared response payload
//               eth_*                     controller MMIO port
//
// Revision    : 1.0 - initial release
// ============================================================================
module eth_mmio_arbiter #(
    parameter int num_req_p    = 2,
    parameter int data_width_p = 32,
    parameter int addr_width_p = 14,
    parameter int size_width_p = $clog2(data_width_p / 8)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_ready_o,
    input  logic [num_req_p-1:0]              req_we_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*size_width_p-1:0] req_size_i,
    input  logic [num_req_p*data_width_p-1:0] req_wdata_i,
    output logic [num_req_p-1:0]              resp_v_o,
    input  logic [num_req_p-1:0]              resp_ready_i,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic                              resp_err_o,
    output logic [addr_width_p-1:0]           eth_addr_o,
    output logic                              eth_write_en_o,
    output logic                              eth_read_en_o,
    output logic [size_width_p-1:0]           eth_op_size_o,
    output logic [data_width_p-1:0]           eth_write_data_o,
    input  logic [data_width_p-1:0]           eth_read_data_i
);

    localparam int IDX_W    = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int MAX_SIZE = $clog2(data_width_p / 8);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                   state_q;
    logic [IDX_W-1:0]         last_q;
    logic [num_req_p-1:0]     grant_oh_q;
    logic                     we_q;
    logic                     err_q;
    logic [data_width_p-1:0]  data_q;
    logic [num_req_p-1:0]     resp_v_q;
    logic                     wr_en_q;
    logic                     rd_en_q;
    logic [addr_width_p-1:0]  eth_addr_q;
    logic [size_width_p-1:0]  eth_size_q;
    logic [data_width_p-1:0]  eth_wdata_q;

    // Arbitration and command-select signals (combinational)
    logic [2*num_req_p-1:0]   req_dbl;
    logic [2*num_req_p-1:0]   req_dbl_sh;
    logic [num_req_p-1:0]     req_rot;
    logic                     grant_v;
    int                       grant_ofs;
    logic [IDX_W-1:0]         grant_idx;
    logic [num_req_p-1:0]     grant_oh;
    logic                     sel_we;
    logic [addr_width_p-1:0]  sel_addr;
    logic [size_width_p-1:0]  sel_size;
    logic [data_width_p-1:0]  sel_wdata;
    logic                     sel_err;

    // Rotate the request vector so bit 0 is the requester just after last_q.
    // The lowest set bit of the rotated vector is then the round-robin winner.
    always_comb begin
        req_dbl    = {req_v_i, req_v_i};
        req_dbl_sh = req_dbl >> (int'(last_q) + 1);
        req_rot    = req_dbl_sh[num_req_p-1:0];
        grant_v    = 1'b0;
        grant_ofs  = 0;
        for (int j = num_req_p - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                grant_v   = 1'b1;
                grant_ofs = j;
            end
        end
        grant_idx = IDX_W'((int'(last_q) + 1 + grant_ofs) % num_req_p);
        for (int i = 0; i < num_req_p; i++) begin
            grant_oh[i] = grant_v && (grant_idx == IDX_W'(i));
        end
    end

    // Select the winning requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_size  = '0;
        sel_wdata = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant_oh[i]) begin
                sel_we    = req_we_i[i];
                sel_addr  = req_addr_i[i*addr_width_p +: addr_width_p];
                sel_size  = req_size_i[i*size_width_p +: size_width_p];
                sel_wdata = req_wdata_i[i*data_width_p +: data_width_p];
            end
        end
    end

`ifdef ETH_MMIO_ADDR_CHECK_EN
    logic [addr_width_p-1:0] align_mask;

    // A request is flagged if its address has any bit set below the access
    // size, or if the size is wider than the data bus.
    always_comb begin
        align_mask = (addr_width_p'(1) << sel_size) - addr_width_p'(1);
        sel_err    = ((sel_addr & align_mask) != '0) || (int'(sel_size) > MAX_SIZE);
    end

    assign resp_err_o = err_q & (|resp_v_q);
`else
    assign sel_err    = 1'b0;
    assign resp_err_o = 1'b0;
`endif

    // Accept is combinational and is allowed only in IDLE. It is gated by
    // reset so that req_ready_o stays 0 while reset is asserted.
    assign req_ready_o = (state_q == ST_IDLE && reset_n_i) ? grant_oh : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            last_q      <= IDX_W'(num_req_p - 1);
            grant_oh_q  <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            resp_v_q    <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            eth_addr_q  <= '0;
            eth_size_q  <= '0;
            eth_wdata_q <= '0;
        end else begin
            // Strobes are one-cycle pulses, asserted only while in ISSUE.
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_v) begin
                        last_q      <= grant_idx;
                        grant_oh_q  <= grant_oh;
                        we_q        <= sel_we;
                        err_q       <= sel_err;
                        eth_addr_q  <= sel_addr;
                        eth_size_q  <= sel_size;
                        eth_wdata_q <= sel_wdata;
                        wr_en_q     <= sel_we & ~sel_err;
                        rd_en_q     <= ~sel_we & ~sel_err;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Controller read data is valid one cycle after the read strobe.
                    data_q   <= (we_q || err_q) ? '0 : eth_read_data_i;
                    resp_v_q <= grant_oh_q;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    if ((resp_ready_i & resp_v_q) != '0) begin
                        resp_v_q <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_v_o         = resp_v_q;
    assign resp_data_o      = data_q;
    assign eth_addr_o       = eth_addr_q;
    assign eth_write_en_o   = wr_en_q;
    assign eth_read_en_o    = rd_en_q;
    assign eth_op_size_o    = eth_size_q;
    assign eth_write_data_o = eth_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_mmio_arbiter
// Description : Scoreboard testbench for eth_mmio_arbiter. The stimulus
//               process pushes the expected controller strobes and responses
//               into queues. Separate monitors pop those queues and compare
//               them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_mmio_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 14;
    localparam int SW = 2;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [N-1:0]    req_v_i, req_ready_o, req_we_i, resp_v_o, resp_ready_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*SW-1:0] req_size_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [DW-1:0]   resp_data_o, eth_write_data_o;
    logic [DW-1:0]   eth_read_data_i = 32'hBAD0BAD0;
    logic            resp_err_o, eth_write_en_o, eth_read_en_o;
    logic [AW-1:0]   eth_addr_o;
    logic [SW-1:0]   eth_op_size_o;

    always #5 clk_i = ~clk_i;

    eth_mmio_arbiter #(
        .num_req_p   (N),
        .data_width_p(DW),
        .addr_width_p(AW)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .req_v_i         (req_v_i),
        .req_ready_o     (req_ready_o),
        .req_we_i        (req_we_i),
        .req_addr_i      (req_addr_i),
        .req_size_i      (req_size_i),
        .req_wdata_i     (req_wdata_i),
        .resp_v_o        (resp_v_o),
        .resp_ready_i    (resp_ready_i),
        .resp_data_o     (resp_data_o),
        .resp_err_o      (resp_err_o),
        .eth_addr_o      (eth_addr_o),
        .eth_write_en_o  (eth_write_en_o),
        .eth_read_en_o   (eth_read_en_o),
        .eth_op_size_o   (eth_op_size_o),
        .eth_write_data_o(eth_write_data_o),
        .eth_read_data_i (eth_read_data_i)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [SW-1:0] size;
        logic [DW-1:0] wdata;
        logic [31:0]   acc;
    } strb_t;

    typedef struct packed {
        logic [N-1:0]  oh;
        logic [DW-1:0] data;
        logic          err;
        logic [31:0]   acc;
    } resp_t;

    strb_t strb_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Controller read path: data is valid only in the cycle after the read
    // strobe. In every other cycle the bus carries a marker value.
    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (a == 14'h0010) return 32'hDEADBEEF;
        return 32'hC0DE0000 | 32'(a);
    endfunction

    always @(posedge clk_i)
        eth_read_data_i <= eth_read_en_o ? rd_model(eth_addr_o) : 32'hBAD0BAD0;

    function automatic logic exp_err(input logic [AW-1:0] a, input logic [SW-1:0] s);
`ifdef ETH_MMIO_ADDR_CHECK_EN
        case (s)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a[1] | a[0];
            default: return 1'b1;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int r, input logic we, input logic [AW-1:0] a,
                            input logic [SW-1:0] s, input logic [DW-1:0] wd, input int acc);
        logic  e;
        strb_t st;
        resp_t rp;
        e = exp_err(a, s);
        if (!e) begin
            st = '{we: we, addr: a, size: s, wdata: wd, acc: 32'(acc)};
            strb_q.push_back(st);
        end
        rp.oh   = N'(1) << r;
        rp.data = (we || e) ? 32'h0 : rd_model(a);
        rp.err  = e;
        rp.acc  = 32'(acc);
        resp_q.push_back(rp);
    endtask

    // Strobe monitor and invariants
    strb_t ms;
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            check("strobe_exclusive", 64'(eth_write_en_o & eth_read_en_o), 0);
            check("ready_onehot", 64'($countones(req_ready_o) <= 1), 1);
            if (eth_write_en_o || eth_read_en_o) begin
                check("strobe_expected", 64'(strb_q.size() != 0), 1);
                if (strb_q.size() != 0) begin
                    ms = strb_q.pop_front();
                    check("strobe_we", 64'(eth_write_en_o), 64'(ms.we));
                    check("strobe_addr", 64'(eth_addr_o), 64'(ms.addr));
                    check("strobe_size", 64'(eth_op_size_o), 64'(ms.size));
                    check("strobe_wdata", 64'(eth_write_data_o), 64'(ms.wdata));
                    check("strobe_latency", 64'(cyc), 64'(ms.acc + 1));
                end
            end
        end
    end

    // Response monitor
    resp_t mr;
    logic  resp_prev = 1'b0;
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if (resp_v_o != '0 && !resp_prev && resp_q.size() != 0)
                check("resp_latency", 64'(cyc), 64'(resp_q[0].acc + 3));
            if ((resp_v_o & resp_ready_i) != '0) begin
                check("resp_expected", 64'(resp_q.size() != 0), 1);
                if (resp_q.size() != 0) begin
                    mr = resp_q.pop_front();
                    check("resp_oh", 64'(resp_v_o), 64'(mr.oh));
                    check("resp_data", 64'(resp_data_o), 64'(mr.data));
                    check("resp_err", 64'(resp_err_o), 64'(mr.err));
                end
            end
            resp_prev = (resp_v_o != '0);
        end else begin
            resp_prev = 1'b0;
        end
    end

    task automatic set_req(input int r, input logic we, input logic [AW-1:0] a,
                           input logic [SW-1:0] s, input logic [DW-1:0] wd);
        req_we_i[r[0]]          = we;
        req_addr_i[r*AW +: AW]  = a;
        req_size_i[r*SW +: SW]  = s;
        req_wdata_i[r*DW +: DW] = wd;
    endtask

    task automatic do_txn(input int r, input logic we, input logic [AW-1:0] a,
                          input logic [SW-1:0] s, input logic [DW-1:0] wd);
        bit done = 1'b0;
        @(posedge clk_i); #1;
        set_req(r, we, a, s, wd);
        req_v_i[r[0]] = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk_i);
            if (req_ready_o != '0) begin
                check("grant_single", 64'(req_ready_o), 64'(N'(1) << r));
                push_exp(r, we, a, s, wd, cyc);
                done = 1'b1;
            end
        end
        check("grant_timeout", 64'(done), 1);
        @(posedge clk_i); #1;
        req_v_i[r[0]] = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 80 && !ok; k++) begin
            @(negedge clk_i);
            if (resp_q.size() == 0 && strb_q.size() == 0) ok = 1'b1;
        end
        check("drain_timeout", 64'(ok), 1);
    endtask

    // Both requesters stay valid. Requester 0 issues reads and requester 1
    // issues writes; grants must strictly alternate, starting with 'first'.
    task automatic contend(input int n, input int first);
        int            k   = 0;
        int            tmo = 0;
        int            r;
        logic [AW-1:0] a0 = 14'h0100, a1 = 14'h0200;
        logic [DW-1:0] w0 = 32'h5A5A0000, w1 = 32'h11110000;
        @(posedge clk_i); #1;
        set_req(0, 1'b0, a0, 2'd2, w0);
        set_req(1, 1'b1, a1, 2'd2, w1);
        req_v_i = 2'b11;
        while (k < n && tmo < 200) begin
            @(negedge clk_i);
            tmo++;
            if (req_ready_o != '0) begin
                r = (first + k) % 2;
                check("rr_order", 64'(req_ready_o), 64'(N'(1) << r));
                if (r == 0) push_exp(0, 1'b0, a0, 2'd2, w0, cyc);
                else        push_exp(1, 1'b1, a1, 2'd2, w1, cyc);
                @(posedge clk_i); #1;
                k++;
                if (r == 0) begin
                    a0 = a0 + 14'd4; w0 = w0 + 32'd1;
                    set_req(0, 1'b0, a0, 2'd2, w0);
                end else begin
                    a1 = a1 + 14'd4; w1 = w1 + 32'd1;
                    set_req(1, 1'b1, a1, 2'd2, w1);
                end
            end
        end
        req_v_i = 2'b00;
        check("contend_count", 64'(k), 64'(n));
    endtask

    logic [DW-1:0] hold_data;
    logic [N-1:0]  hold_v;
    bit            seen;

    initial begin
        reset_n_i    = 1'b0;
        req_v_i      = 2'b11;
        req_we_i     = '0;
        req_addr_i   = '0;
        req_size_i   = '0;
        req_wdata_i  = '0;
        resp_ready_i = 2'b11;

        // Reset state
        #12;
        check("rst_ready", 64'(req_ready_o), 0);
        check("rst_resp", 64'({resp_v_o, resp_err_o}), 0);
        check("rst_resp_data", 64'(resp_data_o), 0);
        check("rst_eth_ctl", 64'({eth_addr_o, eth_op_size_o, eth_write_en_o, eth_read_en_o}), 0);
        check("rst_eth_wdata", 64'(eth_write_data_o), 0);
        req_v_i = 2'b00;
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Single read, then single write
        do_txn(0, 1'b0, 14'h0010, 2'd2, 32'h0);
        wait_done();
        do_txn(1, 1'b1, 14'h0804, 2'd0, 32'h000000A5);
        wait_done();

        // Contention: six alternating grants
        contend(6, 0);
        wait_done();

        // Backpressure. Only the non-granted requester's ready is high, and
        // that ready must be ignored.
        resp_ready_i = 2'b10;
        do_txn(0, 1'b0, 14'h0040, 2'd2, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_i);
            if (resp_v_o != '0) seen = 1'b1;
        end
        check("bp_resp_seen", 64'(seen), 1);
        hold_data = resp_data_o;
        hold_v    = resp_v_o;
        set_req(1, 1'b1, 14'h0300, 2'd2, 32'h0000CAFE);
        req_v_i[1] = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            check("bp_v_stable", 64'(resp_v_o), 64'(hold_v));
            check("bp_data_stable", 64'(resp_data_o), 64'(hold_data));
            check("bp_no_ready", 64'(req_ready_o), 0);
        end
        @(posedge clk_i); #1;
        req_v_i[1]   = 1'b0;
        resp_ready_i = 2'b11;
        wait_done();

        // Address checking: a misaligned word, an aligned half, an oversized access
        do_txn(0, 1'b0, 14'h0002, 2'd2, 32'h0);
        wait_done();
        do_txn(1, 1'b0, 14'h0006, 2'd1, 32'h0);
        wait_done();
        do_txn(0, 1'b0, 14'h0008, 2'd3, 32'h0);
        wait_done();

        // Reset asserted during CAPTURE
        do_txn(1, 1'b0, 14'h0020, 2'd2, 32'h12345678);
        @(posedge clk_i); #2;
        reset_n_i = 1'b0;
        req_v_i   = 2'b11;
        resp_q.delete();
        strb_q.delete();
        #1;
        check("mid_rst_ready", 64'(req_ready_o), 0);
        check("mid_rst_resp", 64'({resp_v_o, resp_err_o}), 0);
        check("mid_rst_resp_data", 64'(resp_data_o), 0);
        check("mid_rst_eth_ctl", 64'({eth_addr_o, eth_op_size_o, eth_write_en_o, eth_read_en_o}), 0);
        check("mid_rst_eth_wdata", 64'(eth_write_data_o), 0);
        req_v_i = 2'b00;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        contend(2, 0);
        wait_done();

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/eth_mmio_arbiter.md
Name: eth_mmio_arbiter

Overview:
- Shares the single sync-read MMIO port of the ethernet controller among num_req_p requesters, e.g. the host bridge and an on-chip packet DMA.
- Round-robin arbitration; one outstanding transaction at a time.
- Each transaction is sequenced as: accept, single-cycle strobe, capture, response handshake.
- Sits between the core-side interconnect and the ethernet controller wrapper, in the clk_i domain.

Parameters:
- num_req_p, 2, number of requesters (2..4).
- data_width_p, 32, MMIO data width; must match the controller.
- addr_width_p, 14, MMIO byte-address width.
- size_width_p, derived: width of clog2(data_width_p/8), op_size encoding where 0=byte, 1=half, 2=word...

Ports:
- clk_i  in  1  clock, same clock as the controller's clk_i.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- req_v_i  in  num_req_p  per-requester request valid.
- req_ready_o  out  num_req_p  per-requester request accept, one-hot or zero.
- req_we_i  in  num_req_p  1=write, 0=read.
- req_addr_i  in  num_req_p*addr_width_p  packed addresses; requester i occupies slice i.
- req_size_i  in  num_req_p*size_width_p  packed op sizes.
- req_wdata_i  in  num_req_p*data_width_p  packed write data.
- resp_v_o  out  num_req_p  response valid, one-hot or zero.
- resp_ready_i  in  num_req_p  response accept.
- resp_data_o  out  data_width_p  read data; shared by all requesters and qualified by resp_v_o.
- resp_err_o  out  1  error flag, qualified by resp_v_o.
- eth_addr_o  out  addr_width_p  to controller addr_i.
- eth_write_en_o  out  1  to controller write_en_i.
- eth_read_en_o  out  1  to controller read_en_i.
- eth_op_size_o  out  size_width_p  to controller op_size_i.
- eth_write_data_o  out  data_width_p  to controller write_data_i.
- eth_read_data_i  in  data_width_p  from controller read_data_o; valid the cycle after eth_read_en_o.

Behaviour:
Reset:
- Reset is asynchronous and active-low, and releases synchronously to clk_i.
- While reset_n_i=0: state=IDLE, all outputs 0, round-robin pointer last_r=num_req_p-1, so requester 0 wins first.

FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_v_i is set, grant the first valid requester searching from last_r+1 with wrap-around.
  - Assert req_ready_o[grant] combinationally in the same cycle.
  - Latch grant, we, addr, size and wdata into the internal registers.
  - Update last_r=grant and go to ISSUE.
  - If no req_v_i is set, stay in IDLE.
- ISSUE:
  - Drive eth_addr_o, eth_op_size_o and eth_write_data_o from the latched registers; these hold stable from ISSUE through CAPTURE.
  - Assert eth_write_en_o (if we) or eth_read_en_o (if not we) for exactly one cycle.
  - Go to CAPTURE.
- CAPTURE:
  - For reads, register eth_read_data_i into data_r.
  - For writes, data_r=0.
  - Go to RESP.
- RESP:
  - Assert resp_v_o[grant]=1, with resp_data_o=data_r and resp_err_o=err_r.
  - Hold until resp_ready_i[grant]=1.
  - Then go to IDLE; the next grant is possible in that IDLE cycle.

Timing and rules:
- Latency: accept cycle T, strobe at T+1, capture at T+2, resp_v_o from T+3. Minimum 4 cycles per transaction.
- No new request is accepted outside IDLE; req_ready_o=0 in all other states.
- eth_write_en_o and eth_read_en_o are never high together and never high outside ISSUE.
- Outside ISSUE/CAPTURE, eth_addr_o, eth_op_size_o and eth_write_data_o hold their last values; they are 0 after reset.
- resp_ready_i of non-granted requesters is ignored.
- A requester may drop req_v_i before it is granted; nothing is latched for it.
- Reset asserted mid-transaction: the transaction is abandoned and no response is issued. If the strobe was already issued, its side effect in the controller stands.
- Simultaneous requests: strict rotation. With two requesters continuously valid, grants alternate 0,1,0,1.

Optional Feature:
ETH_MMIO_ADDR_CHECK_EN
- Defined: in IDLE, a request is flagged as an error if either:
  - addr is misaligned, i.e. addr & ((1<<size)-1) != 0; or
  - size > clog2(data_width_p/8).
- A flagged request still follows IDLE->ISSUE->CAPTURE->RESP, but no eth_*_en_o strobe is issued.
- Its response carries data_r=0 and resp_err_o=1.
- Undefined: no checking; every request is forwarded and resp_err_o is tied 0.

Test Plan:
- Single read: req 0 reads addr 0x0010, size 2; controller returns 0xDEADBEEF → eth_read_en_o=1 for exactly one cycle at T+1; resp_v_o=01 at T+3 with resp_data_o=0xDEADBEEF.
- Write: req 1 writes 0x0000_00A5 to 0x0804, size 0 → eth_write_en_o pulses once with addr 0x0804, size 0, data 0xA5; resp_v_o=10, resp_data_o=0, resp_err_o=0.
- Contention: both requesters valid continuously for 6 transactions → grant order 0,1,0,1,0,1; req_ready_o is never 11.
- Backpressure: resp_ready_i held 0 for 10 cycles → resp_v_o and resp_data_o are stable, no further eth strobes occur, req_ready_o=0 throughout.
- Reset mid-op: drop reset_n_i during CAPTURE → all outputs go to 0 immediately (asynchronous); after release, requester 0 is served first.
- ETH_MMIO_ADDR_CHECK_EN: word read at addr 0x0002 → no eth strobe; resp_err_o=1, resp_data_o=0. Without the macro, the same request issues a strobe and returns resp_err_o=0.
